// File: rtl/team_06_timer_pkg.sv
// Shared types and default sizes for the elevator shared-timer scheduler.
// Imported by the round-robin arbiter and the scheduler top.
package team_06_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } timer_state_t;

    localparam int NREQ_DEF = 3;
    localparam int CW_DEF   = 8;
    localparam int IW_DEF   = 2;

endpackage

// File: rtl/team_06_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_ptr,
// wrapping modulo NREQ.
module team_06_rr_arbiter
    import team_06_timer_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_ptr,
    output logic            any_req,
    output logic [IW-1:0]   winner
);

    int idx;

    // Walk the ring farthest-first so the nearest requester overwrites last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_ptr) + k) % NREQ;
            if (req[idx]) begin
                any_req = 1'b1;
                winner  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/team_06_timer_sched.sv
// Shared countdown timer: round-robin grant, one delay in flight,
// per-requester done pulse and cancel of the active delay.
module team_06_timer_sched
    import team_06_timer_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              div_lvl,
    input  logic              div_lvl_past,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] dur,
    input  logic [NREQ-1:0]   cancel,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [CW-1:0]     remaining
);

    timer_state_t    state_q, state_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;

    logic            tick;
    logic            any_req;
    logic [IW-1:0]   win;
    logic [CW-1:0]   win_dur;

    assign tick    = div_lvl & ~div_lvl_past;
    assign win_dur = dur[int'(win)*CW +: CW];

    team_06_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req      (req),
        .last_ptr (ptr_q),
        .any_req  (any_req),
        .winner   (win)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        grant_d = grant_q;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (any_req) begin
                    cur_d = win;
                    ptr_d = win;
                    rem_d = win_dur;
                    if (win_dur != '0) begin
                        state_d = RUN;
                        grant_d = NREQ'(1) << win;
                    end else begin
                        state_d = DONE;
                        done_d  = NREQ'(1) << win;
                    end
                end
            end
            RUN: begin
                // Cancel wins over an expiry landing in the same cycle.
                if (cancel[cur_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rem_d   = '0;
                end else if (tick) begin
                    if (rem_q == CW'(1)) begin
                        state_d = DONE;
                        grant_d = '0;
                        rem_d   = '0;
                        done_d  = NREQ'(1) << cur_q;
                    end else begin
                        rem_d = rem_q - CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                rem_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            rem_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign remaining = rem_q;

endmodule

// File: tb/tb_team_06_timer_sched.sv
// Scoreboard bench for team_06_timer_sched: a job-level reference model
// predicts each cycle's outputs; a monitor pops and compares.
module tb_team_06_timer_sched;

    localparam int N  = 3;
    localparam int CW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            nrst = 1'b1;
    logic            div_lvl = 1'b0;
    logic            div_lvl_past = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    cancel = '0;
    logic [N*CW-1:0] dur = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [CW-1:0]   remaining;

    team_06_timer_sched #(
        .NREQ (N),
        .CW   (CW),
        .IW   (IW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .div_lvl      (div_lvl),
        .div_lvl_past (div_lvl_past),
        .req          (req),
        .dur          (dur),
        .cancel       (cancel),
        .grant        (grant),
        .done         (done),
        .busy         (busy),
        .remaining    (remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic          b;
        logic [CW-1:0] r;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: which job is running, ticks left, last winner,
    // and which requester is in its completion cycle (-1 = none).
    int m_act  = -1;
    int m_left = 0;
    int m_ptr  = N - 1;
    int m_done = -1;

    logic [N-1:0] rq = '0;
    bit           rst_drive = 1'b1;
    int           durs[N];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req_v, $time);
        end
    endtask

    task automatic model_reset();
        m_act  = -1;
        m_left = 0;
        m_ptr  = N - 1;
        m_done = -1;
    endtask

    task automatic model_step();
        bit tk;
        tk = div_lvl & ~div_lvl_past;
        if (!nrst) begin
            model_reset();
        end else if (m_done >= 0) begin
            m_done = -1;
        end else if (m_act >= 0) begin
            if (cancel[m_act]) begin
                m_act = -1;
            end else if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = m_act;
                    m_act  = -1;
                end
            end
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (req[idx]) begin
                    m_ptr  = idx;
                    m_left = int'(dur[idx*CW +: CW]);
                    if (m_left == 0) m_done = idx;
                    else m_act = idx;
                    break;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [N-1:0] one;
        one = 1;
        e.g = (m_act >= 0) ? (one << m_act) : '0;
        e.d = (m_done >= 0) ? (one << m_done) : '0;
        e.b = (m_act >= 0) || (m_done >= 0);
        e.r = (m_act >= 0) ? CW'(m_left) : '0;
        return e;
    endfunction

    task automatic cyc(input bit tk, input logic [N-1:0] cn);
        @(negedge clk);
        if (m_done >= 0) rq[m_done] = 1'b0;
        nrst   = rst_drive;
        req    = rq;
        cancel = cn;
        for (int i = 0; i < N; i++) dur[i*CW +: CW] = CW'(durs[i]);
        if (tk) begin
            div_lvl = 1'b1;
            div_lvl_past = 1'b0;
        end else begin
            case ($urandom_range(2))
                0: begin div_lvl = 1'b0; div_lvl_past = 1'b0; end
                1: begin div_lvl = 1'b1; div_lvl_past = 1'b1; end
                default: begin div_lvl = 1'b0; div_lvl_past = 1'b1; end
            endcase
        end
        model_step();
        q.push_back(model_out());
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        rst_drive = 1'b0;
        #1;
        chk({nm, "_grant"}, 32'(grant), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_rem"}, 32'(remaining), 32'd0);
        model_reset();
        cyc(1'b1, '0);
        cyc(1'b0, '0);
        rst_drive = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", 32'(grant), 32'(e.g));
                chk("done", 32'(done), 32'(e.d));
                chk("busy", 32'(busy), 32'(e.b));
                chk("remaining", 32'(remaining), 32'(e.r));
            end
        end
    end

    initial begin : driver
        logic [N-1:0] cn;
        for (int i = 0; i < N; i++) durs[i] = 0;
        #3;
        nrst = 1'b0;
        rst_drive = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rem", 32'(remaining), 32'd0);
        model_reset();
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        rst_drive = 1'b1;
        cyc(1'b0, '0);

        // single job, tick every 4 clocks
        durs[0] = 3;
        rq = 3'b001;
        for (int i = 0; i < 20; i++) cyc(i % 4 == 3, '0);

        // all three contend, unit durations
        for (int i = 0; i < N; i++) durs[i] = 1;
        rq = 3'b111;
        for (int i = 0; i < 24; i++) cyc(i % 2 == 1, '0);

        // zero duration skips RUN
        durs[1] = 0;
        rq = 3'b010;
        for (int i = 0; i < 5; i++) cyc(1'b1, '0);

        // cancel mid-run, requester 0 waiting behind
        durs[0] = 2;
        durs[2] = 5;
        rq = 3'b101;
        for (int i = 0; i < 40; i++) begin
            if (m_act == 2 && m_left == 3) begin
                cyc(1'b0, 3'b100);
                rq[2] = 1'b0;
                break;
            end
            cyc(i % 3 == 0, '0);
        end
        for (int i = 0; i < 15; i++) cyc(i % 2 == 0, '0);

        // cancel on other index, then cancel coinciding with final tick
        durs[0] = 2;
        rq = 3'b001;
        for (int i = 0; i < 20; i++) begin
            if (m_act == 0 && m_left == 2) begin
                cyc(1'b1, 3'b010);
            end else if (m_act == 0 && m_left == 1) begin
                cyc(1'b1, 3'b001);
                rq = '0;
                break;
            end else begin
                cyc(1'b0, '0);
            end
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, '0);

        // asynchronous reset mid-run, then req0 beats req1
        durs[2] = 9;
        rq = 3'b100;
        for (int i = 0; i < 6; i++) cyc(1'b1, '0);
        rq = 3'b011;
        durs[0] = 2;
        durs[1] = 2;
        async_reset("mid_rst");
        for (int i = 0; i < 20; i++) cyc(i % 2 == 0, '0);

        // randomized traffic with random durations, ticks and cancels
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(7) == 0) rq[i] = 1'b1;
                durs[i] = $urandom_range(5);
            end
            cn = '0;
            if ($urandom_range(15) == 0) cn[$urandom_range(N - 1)] = 1'b1;
            cyc($urandom_range(2) == 0, cn);
            for (int i = 0; i < N; i++) begin
                if (cn[i] && $urandom_range(1) == 0) rq[i] = 1'b0;
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
